// File: rtl/regfile_4x16_pkg.sv
// Shared sizing and reset constants for the 4x16 register file and its read muxes.
package regfile_4x16_pkg;

   localparam int          REG_ADDR_W = 2;
   localparam int          NUM_REGS   = 4;
   localparam int          WIDTH      = 16;
   localparam logic [15:0] RESET_VAL  = 16'h0000;

endpackage

// File: rtl/mux16bit.sv
// 16-bit 4:1 read mux; one instance per register-file read port.
module mux16bit (
   input  logic [15:0] d0,
   input  logic [15:0] d1,
   input  logic [15:0] d2,
   input  logic [15:0] d3,
   input  logic [1:0]  sel,
   output logic [15:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/regfile_4x16.sv
// Four-entry 16-bit register file: one write port, two async read ports with
// write-through bypass, and a per-register pending scoreboard for operand stalls.
module regfile_4x16 #(
   parameter int          WIDTH     = regfile_4x16_pkg::WIDTH,
   parameter logic [15:0] RESET_VAL = regfile_4x16_pkg::RESET_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             iss_en,
   input  logic [1:0]       iss_addr,
   input  logic [1:0]       rd_addr_a,
   input  logic [1:0]       rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             busy_a,
   output logic             busy_b,
   output logic [3:0]       pend_vec
);

   import regfile_4x16_pkg::*;

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];
   logic [3:0]       pend_q;
   logic [3:0]       pend_d;

   logic [WIDTH-1:0] mux_a;
   logic [WIDTH-1:0] mux_b;
   logic             byp_a;
   logic             byp_b;
   logic             reiss_a;
   logic             reiss_b;

   // Issue is applied after write so a same-register issue leaves pend set.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (clr) begin
         for (int i = 0; i < NUM_REGS; i++) regs_d[i] = RESET_VAL;
         pend_d = 4'b0000;
      end else begin
         if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
         end
         if (iss_en) pend_d[iss_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
         pend_q <= 4'b0000;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   mux16bit u_mux_a (
      .d0  (regs_q[0]),
      .d1  (regs_q[1]),
      .d2  (regs_q[2]),
      .d3  (regs_q[3]),
      .sel (rd_addr_a),
      .y   (mux_a)
   );

   mux16bit u_mux_b (
      .d0  (regs_q[0]),
      .d1  (regs_q[1]),
      .d2  (regs_q[2]),
      .d3  (regs_q[3]),
      .sel (rd_addr_b),
      .y   (mux_b)
   );

   // Bypass is independent of rst/clr: the in-flight write is visible this cycle.
   always_comb begin
      byp_a   = wr_en  && (wr_addr  == rd_addr_a);
      byp_b   = wr_en  && (wr_addr  == rd_addr_b);
      reiss_a = iss_en && (iss_addr == rd_addr_a);
      reiss_b = iss_en && (iss_addr == rd_addr_b);

      rd_data_a = byp_a ? wr_data : mux_a;
      rd_data_b = byp_b ? wr_data : mux_b;
      busy_a    = pend_q[rd_addr_a] && !(byp_a && !reiss_a);
      busy_b    = pend_q[rd_addr_b] && !(byp_b && !reiss_b);
      pend_vec  = pend_q;
   end

endmodule

// File: tb/tb_regfile_4x16.sv
// Randomized and directed bench for regfile_4x16 against an array-based reference model.
module tb_regfile_4x16;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic        iss_en;
   logic [1:0]  iss_addr;
   logic [1:0]  rd_addr_a;
   logic [1:0]  rd_addr_b;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic        busy_a;
   logic        busy_b;
   logic [3:0]  pend_vec;

   logic [15:0] m_regs [4];
   logic        m_pend [4];
   int          checks;
   int          failures;

   regfile_4x16 dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .pend_vec  (pend_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_data(input logic [1:0] a);
      if (wr_en && wr_addr == a) return wr_data;
      return m_regs[a];
   endfunction

   // Pending unless this cycle's write to the register clears it without a new issue.
   function automatic logic exp_busy(input logic [1:0] a);
      logic wr_hit;
      logic iss_hit;
      wr_hit  = wr_en && wr_addr == a;
      iss_hit = iss_en && iss_addr == a;
      return m_pend[a] && !(wr_hit && !iss_hit);
   endfunction

   function automatic logic [3:0] exp_pend();
      return {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
   endfunction

   // One clock: drive at negedge, check outputs mid-cycle, advance model at posedge.
   task automatic step(input string tag, input logic i_rst, input logic i_clr,
                       input logic i_we, input logic [1:0] i_wa, input logic [15:0] i_wd,
                       input logic i_ie, input logic [1:0] i_ia,
                       input logic [1:0] i_ra, input logic [1:0] i_rb);
      @(negedge clk);
      rst = i_rst; clr = i_clr; wr_en = i_we; wr_addr = i_wa; wr_data = i_wd;
      iss_en = i_ie; iss_addr = i_ia; rd_addr_a = i_ra; rd_addr_b = i_rb;
      #1;
      check({tag, "_rd_a"}, rd_data_a, exp_data(i_ra));
      check({tag, "_rd_b"}, rd_data_b, exp_data(i_rb));
      check({tag, "_busy_a"}, {15'b0, busy_a}, {15'b0, exp_busy(i_ra)});
      check({tag, "_busy_b"}, {15'b0, busy_b}, {15'b0, exp_busy(i_rb)});
      check({tag, "_pend"}, {12'b0, pend_vec}, {12'b0, exp_pend()});
      @(posedge clk);
      if (i_rst || i_clr) begin
         for (int i = 0; i < 4; i++) begin
            m_regs[i] = 16'h0000;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (i_we) begin
            m_regs[i_wa] = i_wd;
            m_pend[i_wa] = 1'b0;
         end
         if (i_ie) m_pend[i_ia] = 1'b1;
      end
   endtask

   task automatic idle(input string tag, input logic [1:0] ra, input logic [1:0] rb);
      step(tag, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, ra, rb);
   endtask

   task automatic wr(input string tag, input logic [1:0] wa, input logic [15:0] wd,
                     input logic [1:0] ra);
      step(tag, 1'b0, 1'b0, 1'b1, wa, wd, 1'b0, 2'd0, ra, ra);
   endtask

   task automatic iss(input string tag, input logic [1:0] ia, input logic [1:0] ra);
      step(tag, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, ia, ra, ra);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0000;
      iss_en = 1'b0; iss_addr = 2'd0; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
      for (int i = 0; i < 4; i++) begin
         m_regs[i] = 16'h0000;
         m_pend[i] = 1'b0;
      end
      repeat (2) @(posedge clk);

      // Reset state on every address
      for (int a = 0; a < 4; a++) idle("reset", 2'(a), 2'(3 - a));
      check("reset_r2_const", rd_data_a, 16'h0000);

      // Basic write / read, both ports on the same register
      wr("wr_r2", 2'd2, 16'hA5A5, 2'd0);
      wr("wr_r3", 2'd3, 16'h1234, 2'd0);
      idle("rd_2_3", 2'd2, 2'd3);
      check("tp_a5a5", rd_data_a, 16'hA5A5);
      check("tp_1234", rd_data_b, 16'h1234);
      idle("rd_2_2", 2'd2, 2'd2);

      // Write-through bypass
      wr("wr_r1", 2'd1, 16'h0001, 2'd0);
      wr("byp_r1", 2'd1, 16'hBEEF, 2'd1);
      idle("after_byp", 2'd1, 2'd0);
      check("tp_beef", rd_data_a, 16'hBEEF);

      // Scoreboard set / clear / same-cycle issue wins
      iss("iss_r3", 2'd3, 2'd0);
      idle("busy_r3", 2'd3, 2'd0);
      check("tp_pend_1000", {12'b0, pend_vec}, 16'h0008);
      wr("wr_r3_clr", 2'd3, 16'h00FF, 2'd3);
      idle("r3_free", 2'd3, 2'd0);
      step("iss_wr_r0", 1'b0, 1'b0, 1'b1, 2'd0, 16'h7777, 1'b1, 2'd0, 2'd0, 2'd1);
      idle("r0_pend", 2'd0, 2'd1);
      check("tp_r0_7777", rd_data_a, 16'h7777);
      check("tp_pend_0001", {12'b0, pend_vec}, 16'h0001);
      step("iss_wr_diff", 1'b0, 1'b0, 1'b1, 2'd1, 16'h4321, 1'b1, 2'd2, 2'd1, 2'd2);
      idle("diff_after", 2'd1, 2'd2);

      // clr wipes regs and scoreboard
      for (int i = 0; i < 4; i++) wr("load", 2'(i), 16'h1111 * 16'(i + 1), 2'(i));
      for (int i = 0; i < 4; i++) iss("load_iss", 2'(i), 2'(i));
      idle("loaded", 2'd0, 2'd3);
      check("tp_pend_1111", {12'b0, pend_vec}, 16'h000F);
      step("clr", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd1, 2'd2);
      for (int a = 0; a < 4; a++) idle("after_clr", 2'(a), 2'(a));
      check("tp_clr_pend", {12'b0, pend_vec}, 16'h0000);

      // rst discards a concurrent write (bypass still visible that cycle)
      step("rst_wr", 1'b1, 1'b0, 1'b1, 2'd2, 16'hFFFF, 1'b1, 2'd1, 2'd2, 2'd1);
      idle("after_rst", 2'd2, 2'd1);
      check("tp_rst_r2", rd_data_a, 16'h0000);
      step("clr_wr", 1'b0, 1'b1, 1'b1, 2'd3, 16'hFFFF, 1'b1, 2'd3, 2'd3, 2'd0);
      idle("after_clr_wr", 2'd3, 2'd0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         step("rand",
              $urandom_range(0, 49) == 0,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 1) == 1,
              2'($urandom_range(0, 3)),
              16'($urandom),
              $urandom_range(0, 2) == 0,
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_4x16.md
Name: regfile_4x16

Overview:
Four-entry, 16-bit architectural register file for the RISC datapath: 1 write port, 2 asynchronous read ports (A, B).
Read ports are built from the existing 16-bit 4:1 read mux, one instance per port, selected by 2-bit register addresses.
Includes a per-register pending scoreboard so the control unit can stall on operands whose write-back is outstanding.
Sits between the write-back stage (upstream) and the ALU operand latches (downstream).

Parameters:
WIDTH, 16, data width of each register; must stay 16 to match the read mux.
RESET_VAL, 16'h0000, value loaded into every register on reset or clear.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
clr  input  1  synchronous clear of all registers and scoreboard; lower priority than rst.
wr_en  input  1  write strobe.
wr_addr  input  2  destination register of the write.
wr_data  input  16  write data.
iss_en  input  1  marks iss_addr pending (instruction with long-latency result issued).
iss_addr  input  2  register to mark pending.
rd_addr_a  input  2  read port A select.
rd_addr_b  input  2  read port B select.
rd_data_a  output  16  read port A data.
rd_data_b  output  16  read port B data.
busy_a  output  1  register at rd_addr_a is pending.
busy_b  output  1  register at rd_addr_b is pending.
pend_vec  output  4  raw scoreboard, bit n = register n pending.

Behaviour:
- State: r0..r3 (16b each), pend[3:0]. All update only on the rising edge of clk.
- Priority at each edge: rst > clr > normal operation. rst and clr have identical effect: r0..r3 <= RESET_VAL, pend <= 4'b0000.
- Reset values: rd_data_a/b = RESET_VAL; busy_a/b = 0; pend_vec = 0. All outputs are combinational from state, so they follow one edge after rst.
- Write: wr_en=1 -> r[wr_addr] <= wr_data at the edge, and pend[wr_addr] <= 0.
- Issue: iss_en=1 -> pend[iss_addr] <= 1.
- Issue and write to the same register in the same cycle: data is written and pend ends at 1 (issue wins; it belongs to a newer instruction).
- Issue and write to different registers: both take effect.
- Read (0-cycle latency, combinational):
  - rd_data_x = r[rd_addr_x].
  - Write-through bypass: if wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle.
  - Ports A and B are independent and may select the same register.
- busy_x = pend[rd_addr_x], except 0 when a same-cycle write to that register is bypassed and not re-issued in that cycle.
- Write while not pending is legal: plain register update, pend stays 0.
- rst/clr asserted in the same cycle as wr_en or iss_en: the write and issue are discarded.
- Bypass is still combinationally visible during that cycle; the state after the edge is the reset state.
- No X propagation: every address value 0..3 is valid. No illegal states exist.

Decomposition:
- Shared package/header: REG_ADDR_W=2, NUM_REGS=4, WIDTH=16, RESET_VAL.
- Sub-module: two instances of the existing 16-bit 4:1 read mux (mux16bit), one per read port, inputs r0..r3.
- Bypass compare and the busy logic stay in this module.

Test Plan:
- Reset: rst=1 for 1 cycle -> rd_data_a/b=16'h0000, pend_vec=4'b0000 for all rd_addr values.
- Write/read: write 16'hA5A5 to r2, 16'h1234 to r3 -> next cycle rd_addr_a=2 gives 16'hA5A5, rd_addr_b=3 gives 16'h1234; both ports on r2 give 16'hA5A5 on both.
- Bypass: r1=16'h0001, then wr_en with wr_addr=1, wr_data=16'hBEEF, rd_addr_a=1 in the same cycle -> rd_data_a=16'hBEEF that cycle and after the edge.
- Scoreboard: iss r3 -> pend_vec=4'b1000, busy_a=1 with rd_addr_a=3; write r3=16'h00FF -> pend_vec=0 next cycle. Simultaneous iss r0 + write r0=16'h7777 -> r0=16'h7777, pend_vec=4'b0001.
- Clear and reset priority:
  - Load all regs non-zero with pend=4'b1111, pulse clr -> all regs 0, pend 0.
  - rst and wr_en (r2=16'hFFFF) in the same cycle -> r2=0 afterwards.
